// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA mode encodings, sequencer states and width defaults
package rsa_pkg;

    localparam int RSA_KEY_W = 32;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_KEYGEN  = 2'b01;
    localparam logic [1:0] MODE_DECRYPT = 2'b10;
    localparam logic [1:0] MODE_ENCRYPT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_EXP_REQ,
        ST_EXP_WAIT,
        ST_TX
    } seq_state_t;

endpackage

// File: rtl/rsa_block_shifter.sv
// rtl/rsa_block_shifter.sv - KEY_W block register with big-endian byte shift in/out and byte counter
module rsa_block_shifter #(
    parameter int KEY_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [KEY_W-1:0] load_data,
    input  logic             shift_in,
    input  logic [7:0]       in_byte,
    input  logic             shift_out,
    output logic [KEY_W-1:0] block,
    output logic [7:0]       out_byte,
    output logic             last
);

    localparam int NB = KEY_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] cnt;

    assign last     = (cnt == CW'(NB - 1));
    assign out_byte = block[KEY_W-1 -: 8];

    // Block register and byte counter; the counter wraps after the last byte so RX and TX share it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block <= '0;
            cnt   <= '0;
        end else if (clr) begin
            block <= '0;
            cnt   <= '0;
        end else if (load) begin
            block <= load_data;
            cnt   <= '0;
        end else if (shift_in) begin
            block <= (block << 8) | KEY_W'(in_byte);
            cnt   <= last ? '0 : cnt + 1'b1;
        end else if (shift_out) begin
            block <= block << 8;
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rsa_crypt_sequencer.sv
// rtl/rsa_crypt_sequencer.sv - sequences the modexp engine for encrypt/decrypt over the UART byte streams
module rsa_crypt_sequencer
    import rsa_pkg::*;
#(
    parameter int KEY_W = RSA_KEY_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [KEY_W-1:0] n_key,
    input  logic [KEY_W-1:0] e_key,
    input  logic [KEY_W-1:0] d_key,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             exp_start,
    output logic             exp_abort,
    output logic [KEY_W-1:0] exp_base,
    output logic [KEY_W-1:0] exp_exp,
    output logic [KEY_W-1:0] exp_mod,
    input  logic             exp_done,
    input  logic [KEY_W-1:0] exp_result,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] block_cnt
);

    seq_state_t state, state_nx;

    logic [1:0]       mode_q;
    logic             stop_pend;
    logic [KEY_W-1:0] block;
    logic [7:0]       sh_byte;
    logic             sh_last;
    logic             sh_clr, sh_load, sh_in, sh_out;

    logic start_req, key_ok, start_go, abort, stop_next, range_bad, rx_fire, tx_fire, in_run;

    assign start_req = (state == ST_IDLE) && start && mode[1];
    assign key_ok    = (n_key >= KEY_W'(2));
    assign start_go  = start_req && key_ok;
    assign abort     = (state != ST_IDLE) && (mode != mode_q);
    assign stop_next = stop_pend || start;
    assign range_bad = (block >= exp_mod);
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    // States after the block is complete: a start here only requests a stop after this block.
    assign in_run    = (state == ST_CHECK) || (state == ST_EXP_REQ) ||
                       (state == ST_EXP_WAIT) || (state == ST_TX);
    assign exp_base  = block;

    rsa_block_shifter #(.KEY_W(KEY_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr       (sh_clr),
        .load      (sh_load),
        .load_data (exp_result),
        .shift_in  (sh_in),
        .in_byte   (rx_data),
        .shift_out (sh_out),
        .block     (block),
        .out_byte  (sh_byte),
        .last      (sh_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: a mode change away from the latched mode overrides everything.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start_go) state_nx = ST_RX;
                ST_RX: begin
                    if (start) state_nx = ST_IDLE;
                    else if (rx_fire && sh_last) state_nx = ST_CHECK;
                end
                ST_CHECK: begin
                    if (range_bad) state_nx = stop_next ? ST_IDLE : ST_RX;
                    else state_nx = ST_EXP_REQ;
                end
                ST_EXP_REQ:  state_nx = ST_EXP_WAIT;
                ST_EXP_WAIT: if (exp_done) state_nx = ST_TX;
                ST_TX:       if (tx_fire && sh_last) state_nx = stop_next ? ST_IDLE : ST_RX;
                default:     state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs and block-shifter controls decoded from the current state.
    always_comb begin
        rx_ready  = (state == ST_RX);
        exp_start = (state == ST_EXP_REQ);
        exp_abort = (state == ST_EXP_WAIT) && abort;
        tx_valid  = (state == ST_TX);
        tx_data   = (state == ST_TX) ? sh_byte : 8'h00;
        busy      = (state != ST_IDLE);
        sh_clr    = start_go;
        sh_load   = (state == ST_EXP_WAIT) && exp_done && !abort;
        sh_in     = (state == ST_RX) && rx_fire && !start && !abort;
        sh_out    = (state == ST_TX) && tx_fire && !abort;
    end

    // Key/mode latches, sticky error, stop request and completed-block counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            exp_exp   <= '0;
            exp_mod   <= '0;
            err       <= 1'b0;
            stop_pend <= 1'b0;
            block_cnt <= '0;
        end else begin
            if (start_req && !key_ok) begin
                err <= 1'b1;
            end
            if (start_go) begin
                mode_q    <= mode;
                exp_mod   <= n_key;
                exp_exp   <= (mode == MODE_ENCRYPT) ? e_key : d_key;
                err       <= 1'b0;
                stop_pend <= 1'b0;
                block_cnt <= '0;
            end
            if ((state == ST_CHECK) && range_bad && !abort) begin
                err <= 1'b1;
            end
            if (in_run && start) begin
                stop_pend <= 1'b1;
            end
            if ((state == ST_TX) && tx_fire && sh_last && !abort && (block_cnt != '1)) begin
                block_cnt <= block_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/rsa_crypt_sequencer.md
Name: rsa_crypt_sequencer

Overview:
- Sequences the shared modular-exponentiation engine for the encrypt (mode 2'b11) and decrypt (mode 2'b10) modes.
- Collects a 32-bit message block from the UART RX byte stream, checks that it is smaller than n, and issues the exponentiation: exponent e when encrypting, d when decrypting.
- Streams the 32-bit result back out as bytes on UART TX.
- Drives busy to the top level. This replaces the temporary "start used as busy" on the display path.

Parameters:
- KEY_W, 32: key, message and result width. Must be a multiple of 8.
- CNT_W, 16: width of the processed-block counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  mode switches: 00 off, 01 keygen, 10 decrypt, 11 encrypt
- start  in  1  one-cycle start/stop pulse, already debounced
- n_key  in  KEY_W  modulus
- e_key  in  KEY_W  public exponent
- d_key  in  KEY_W  private exponent
- rx_data  in  8  UART RX byte
- rx_valid  in  1  RX byte available
- rx_ready  out  1  controller accepts an RX byte
- exp_start  out  1  one-cycle request to the engine
- exp_abort  out  1  one-cycle cancel of an in-flight engine operation
- exp_base  out  KEY_W  message block
- exp_exp  out  KEY_W  latched exponent
- exp_mod  out  KEY_W  latched modulus
- exp_done  in  1  one-cycle completion pulse from the engine
- exp_result  in  KEY_W  engine result, valid while exp_done is high
- tx_data  out  8  UART TX byte
- tx_valid  out  1  TX byte valid
- tx_ready  in  1  UART TX accepts the byte
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error flag
- block_cnt  out  CNT_W  number of blocks completed since the last start

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0. Internal block register, key latches and stop_pend all 0.
- States: IDLE, RX, CHECK, EXP_REQ, EXP_WAIT, TX.
- Handshakes: a byte transfers on a clock edge where valid && ready. Byte order is big-endian; the first byte is the MSB, for both RX and TX.
- IDLE:
  - Leaves only on a start pulse with mode[1]=1.
  - If n_key < 2, set err and stay in IDLE.
  - Otherwise: latch mode; latch exp_mod=n_key; latch exp_exp = e_key (mode 11) or d_key (mode 10); clear err, block_cnt and stop_pend; go to RX.
  - A start pulse in mode 00 or 01 is ignored.
- RX:
  - rx_ready=1. Shift each accepted byte into the block register.
  - After the KEY_W/8-th accepted byte, go to CHECK on the next cycle.
  - A start pulse here goes to IDLE immediately and discards any partial block. A byte accepted in that same cycle is also discarded.
- CHECK (1 cycle):
  - If block >= exp_mod: set err, drop the block, go to RX (or IDLE if stop_pend).
  - Otherwise go to EXP_REQ.
- EXP_REQ (1 cycle): exp_start=1. exp_base, exp_exp and exp_mod stay stable from this cycle until exp_done. Go to EXP_WAIT.
- EXP_WAIT: on exp_done, latch exp_result into the block register and go to TX.
- TX:
  - tx_valid=1 with the current byte. Advance on tx_ready.
  - After the last byte: block_cnt+1, saturating at all-ones. Then go to IDLE if stop_pend, else RX.
- Latency: exp_start rises exactly 2 cycles after the edge that accepts the last RX byte. The first tx_valid is asserted the cycle after exp_done.
- Stop: a start pulse in CHECK, EXP_REQ, EXP_WAIT or TX sets stop_pend. The current block still completes.
- Abort: a mode change away from the latched mode, in any non-IDLE state, goes to IDLE next cycle.
  - If the abort happens in EXP_WAIT, exp_abort pulses for 1 cycle.
  - If exp_done arrives in the same cycle as the abort, the abort wins and the result is dropped.
  - tx_valid drops on abort. A partially sent block is not completed.
- Key inputs are ignored while busy; only the latched values are used.
- err stays set until the next accepted start, or until rst.

Decomposition:
- Shared package rsa_pkg:
  - mode encodings MODE_OFF=2'b00, MODE_KEYGEN=2'b01, MODE_DECRYPT=2'b10, MODE_ENCRYPT=2'b11
  - state enum for this block
  - KEY_W default
- One natural sub-module: rsa_block_shifter. It holds the KEY_W-bit block register, does byte shift-in/shift-out, and keeps the byte counter with its last-byte flag. RX and TX both use it.

Test Plan:
- Encrypt: n=3233, e=17, mode 11, start; RX 00 00 00 41; engine stub returns 65^17 mod 3233 -> exp_start 2 cycles after the 4th byte with base=0x41, exp=17, mod=3233; TX 00 00 0A E6 (2790); block_cnt=1; busy stays 1.
- Decrypt: d=2753, mode 10, start; RX 00 00 0A E6 -> exp_exp=2753; TX 00 00 00 41.
- Range error: n=3233, RX 00 00 0C A1 (3233) -> err=1, no exp_start; then a valid block encrypts normally and err remains 1.
- Stop mid-exponentiation: start pulse in EXP_WAIT -> the block completes all 4 TX bytes, then IDLE; busy=0; block_cnt=1.
- Abort: switch to mode 00 in EXP_WAIT -> exp_abort 1 cycle; next cycle IDLE; a late exp_done produces no tx_valid.
- Backpressure and reset: tx_ready low for 10 cycles -> tx_data held stable. rst during TX -> all outputs 0 asynchronously; n_key=1 then start -> err=1, stays IDLE.
